// File: rtl/ram_pattern_tester_if.sv
// rtl/ram_pattern_tester_if.sv - Avalon-MM master/slave bundle for the pattern tester
interface ram_pattern_tester_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 22
);
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_read;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_waitrequest;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_readdatavalid;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface

// File: rtl/ram_pattern_tester.sv
// rtl/ram_pattern_tester.sv - writes an address-derived pattern over a range, reads it back pipelined and compares
module ram_pattern_tester #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 22,
    parameter int MAX_OUTST = 4,
    parameter int ERR_W     = 16
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W-1:0]    last_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic [ADDR_W-1:0]    first_err_addr,
    output logic [DATA_W-1:0]    first_err_data,
    ram_pattern_tester_if.master avm
);
    localparam int OW = $clog2(MAX_OUTST + 1);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t            state;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] chk_addr;
    logic [OW-1:0]     outst;

    logic              rd_acc;
    logic              wr_acc;
    logic              ret;
    logic              mismatch;
    logic              read_room;
    logic [OW-1:0]     outst_next;
    logic [ERR_W-1:0]  err_next;

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a);
        logic [DATA_W+ADDR_W-1:0] ext;
        logic [DATA_W-1:0]        aw;
        ext = {{DATA_W{1'b0}}, a};
        aw  = ext[DATA_W-1:0];
        case (m)
            2'd0:    pattern = aw;
            2'd1:    pattern = DATA_W'(1) << (a % ADDR_W'(DATA_W));
            2'd2:    pattern = a[0] ? {(DATA_W/8){8'h55}} : {(DATA_W/8){8'hAA}};
            default: pattern = ~aw;
        endcase
    endfunction

    // Returns with nothing outstanding are slave protocol errors and are dropped entirely.
    always_comb begin
        rd_acc     = avm.avm_read && !avm.avm_waitrequest;
        wr_acc     = avm.avm_write && !avm.avm_waitrequest;
        ret        = avm.avm_readdatavalid && (outst != '0);
        outst_next = outst + OW'(rd_acc) - OW'(ret);
        mismatch   = ret && (avm.avm_readdata != pattern(mode_q, chk_addr));
        err_next   = (mismatch && (err_count != '1)) ? err_count + ERR_W'(1) : err_count;
        read_room  = outst_next < OW'(MAX_OUTST);
    end

    assign avm.avm_byteenable = (avm.avm_read || avm.avm_write) ? '1 : '0;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state             <= S_IDLE;
            mode_q            <= '0;
            base_q            <= '0;
            last_q            <= '0;
            chk_addr          <= '0;
            outst             <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            pass              <= 1'b0;
            err_count         <= '0;
            first_err_addr    <= '0;
            first_err_data    <= '0;
            avm.avm_address   <= '0;
            avm.avm_read      <= 1'b0;
            avm.avm_write     <= 1'b0;
            avm.avm_writedata <= '0;
        end else begin
            outst     <= outst_next;
            err_count <= err_next;
            if (mismatch && (err_count == '0)) begin
                first_err_addr <= chk_addr;
                first_err_data <= avm.avm_readdata;
            end
            if (ret) chk_addr <= chk_addr + ADDR_W'(1);

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mode_q         <= mode;
                        base_q         <= base_addr;
                        last_q         <= last_addr;
                        chk_addr       <= base_addr;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        first_err_data <= '0;
                        pass           <= 1'b0;
                        done           <= 1'b0;
                        if (last_addr < base_addr) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state             <= S_WRITE;
                            busy              <= 1'b1;
                            avm.avm_write     <= 1'b1;
                            avm.avm_address   <= base_addr;
                            avm.avm_writedata <= pattern(mode, base_addr);
                        end
                    end
                end
                S_WRITE: begin
                    if (wr_acc) begin
                        // Range end is found by compare, so an all-ones last address never wraps.
                        if (avm.avm_address == last_q) begin
                            state           <= S_READ;
                            avm.avm_write   <= 1'b0;
                            avm.avm_read    <= 1'b1;
                            avm.avm_address <= base_q;
                        end else begin
                            avm.avm_address   <= avm.avm_address + ADDR_W'(1);
                            avm.avm_writedata <= pattern(mode_q, avm.avm_address + ADDR_W'(1));
                        end
                    end
                end
                S_READ: begin
                    if (rd_acc && (avm.avm_address == last_q)) begin
                        state        <= S_DRAIN;
                        avm.avm_read <= 1'b0;
                    end else if (rd_acc) begin
                        avm.avm_address <= avm.avm_address + ADDR_W'(1);
                        avm.avm_read    <= read_room;
                    end else if (!avm.avm_read) begin
                        avm.avm_read <= read_room;
                    end
                end
                S_DRAIN: begin
                    if (outst_next == '0) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_pattern_tester.sv
// tb/tb_ram_pattern_tester.sv - directed bench for ram_pattern_tester with an Avalon-MM memory model
module tb_ram_pattern_tester;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [21:0] base_addr;
    logic [21:0] last_addr;
    logic        busy;
    logic        done;
    logic        pass;
    logic [3:0]  err_count;
    logic [21:0] first_err_addr;
    logic [31:0] first_err_data;

    int checks = 0;
    int errors = 0;

    ram_pattern_tester_if #(.DATA_W(32), .ADDR_W(22)) avm_bus ();

    ram_pattern_tester #(.DATA_W(32), .ADDR_W(22), .MAX_OUTST(4), .ERR_W(4)) dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .start          (start),
        .mode           (mode),
        .base_addr      (base_addr),
        .last_addr      (last_addr),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .first_err_data (first_err_data),
        .avm            (avm_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model state
    logic [31:0] mem [logic [21:0]];
    int          rq_due[$];
    logic [31:0] rq_data[$];
    logic [21:0] wlog_addr[$];
    logic [31:0] wlog_data[$];
    int          cyc = 0;
    int          lat = 3;
    bit          rand_wait = 0;
    bit          corrupt_all = 0;
    logic [21:0] flip_addr = '1;
    logic [31:0] flip_mask = '0;
    logic [1:0]  mode_exp = '0;
    int          n_wr = 0, n_rd = 0, outst_tb = 0, max_outst = 0, wr_bad = 0, stall_bad = 0;
    bit          prev_stall = 0;
    logic        p_rd, p_wr;
    logic [21:0] p_addr;
    logic [31:0] p_data;

    function automatic logic [31:0] exp_pat(input logic [1:0] m, input logic [21:0] a);
        case (m)
            2'd0:    return {10'b0, a};
            2'd1:    return 32'h1 << a[4:0];
            2'd2:    return a[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
            default: return ~{10'b0, a};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: drives inputs for the upcoming edge, cyc+1.
    always @(negedge clk) begin
        logic        w;
        logic [31:0] d;
        if (rst_n && prev_stall &&
            (avm_bus.avm_read !== p_rd || avm_bus.avm_write !== p_wr ||
             avm_bus.avm_address !== p_addr || (p_wr && avm_bus.avm_writedata !== p_data)))
            stall_bad++;
        if (rq_due.size() > 0 && rq_due[0] == cyc + 1) begin
            void'(rq_due.pop_front());
            avm_bus.avm_readdata      = rq_data.pop_front();
            avm_bus.avm_readdatavalid = 1'b1;
            outst_tb--;
        end else begin
            avm_bus.avm_readdata      = $urandom;
            avm_bus.avm_readdatavalid = 1'b0;
        end
        w = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
        avm_bus.avm_waitrequest = w;
        if (avm_bus.avm_read === 1'b1 && !w) begin
            d = mem.exists(avm_bus.avm_address) ? mem[avm_bus.avm_address] : 32'h0;
            if (avm_bus.avm_address == flip_addr) d = d ^ flip_mask;
            if (corrupt_all) d = d ^ 32'h1;
            rq_due.push_back(cyc + 1 + lat);
            rq_data.push_back(d);
            n_rd++;
            outst_tb++;
            if (outst_tb > max_outst) max_outst = outst_tb;
        end
        if (avm_bus.avm_write === 1'b1 && !w) begin
            mem[avm_bus.avm_address] = avm_bus.avm_writedata;
            wlog_addr.push_back(avm_bus.avm_address);
            wlog_data.push_back(avm_bus.avm_writedata);
            n_wr++;
            if (avm_bus.avm_writedata !== exp_pat(mode_exp, avm_bus.avm_address)) wr_bad++;
        end
        prev_stall = (avm_bus.avm_read === 1'b1 || avm_bus.avm_write === 1'b1) && w;
        p_rd   = avm_bus.avm_read;
        p_wr   = avm_bus.avm_write;
        p_addr = avm_bus.avm_address;
        p_data = avm_bus.avm_writedata;
    end

    task automatic run_test(input logic [1:0] m, input logic [21:0] b, input logic [21:0] l,
                            input int poke, output int cyc_n);
        @(negedge clk);
        mode = m; base_addr = b; last_addr = l; start = 1'b1;
        mode_exp = m; n_wr = 0; n_rd = 0; wr_bad = 0; stall_bad = 0; max_outst = 0;
        wlog_addr.delete(); wlog_data.delete();
        @(negedge clk);
        start = 1'b0;
        cyc_n = 0;
        while (!done && cyc_n < 3000) begin
            @(negedge clk);
            cyc_n++;
            if (cyc_n == poke) begin
                start = 1'b1; mode = 2'd3; base_addr = 22'h0; last_addr = 22'h3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_reached", 64'(done), 64'd1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; mode = '0; base_addr = '0; last_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_err", 64'(err_count), 64'd0);
        check("rst_strobes", 64'({avm_bus.avm_read, avm_bus.avm_write}), 64'd0);
        check("rst_addr", 64'(avm_bus.avm_address), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // mode 0, latency 3, zero wait
        run_test(2'd0, 22'h10, 22'h1F, 0, n);
        check("a_cycles", 64'(n), 64'd35);
        check("a_pass", 64'(pass), 64'd1);
        check("a_err", 64'(err_count), 64'd0);
        check("a_nwr", 64'(n_wr), 64'd16);
        check("a_nrd", 64'(n_rd), 64'd16);
        check("a_wrdata", 64'(wr_bad), 64'd0);
        check("a_busy", 64'(busy), 64'd0);

        // mode 1 walking one, bit 5 flipped at 0x25
        flip_addr = 22'h25; flip_mask = 32'h20;
        run_test(2'd1, 22'h20, 22'h3F, 0, n);
        check("b_err", 64'(err_count), 64'd1);
        check("b_first_addr", 64'(first_err_addr), 64'h25);
        check("b_first_data", 64'(first_err_data), 64'h0);
        check("b_pass", 64'(pass), 64'd0);
        check("b_wrdata", 64'(wr_bad), 64'd0);
        flip_addr = '1; flip_mask = '0;

        // mode 2 checkerboard, random stalls, latency 8
        lat = 8; rand_wait = 1;
        run_test(2'd2, 22'h100, 22'h13F, 0, n);
        check("c_max_outst_le4", 64'(max_outst <= 4), 64'd1);
        check("c_stable", 64'(stall_bad), 64'd0);
        check("c_pass", 64'(pass), 64'd1);
        check("c_nrd", 64'(n_rd), 64'd64);
        check("c_wrdata", 64'(wr_bad), 64'd0);
        rand_wait = 0; lat = 3;

        // top of address space, mode 3
        run_test(2'd3, 22'h3FFFFE, 22'h3FFFFF, 0, n);
        check("d_nwr", 64'(n_wr), 64'd2);
        check("d_nrd", 64'(n_rd), 64'd2);
        check("d_data0", 64'(wlog_data[0]), 64'hFFC00001);
        check("d_data1", 64'(wlog_data[1]), 64'hFFC00000);
        check("d_addr1", 64'(wlog_addr[1]), 64'h3FFFFF);
        check("d_pass", 64'(pass), 64'd1);

        // empty range
        run_test(2'd0, 22'h5, 22'h4, 0, n);
        check("e_cycles", 64'(n), 64'd0);
        check("e_pass", 64'(pass), 64'd1);
        check("e_no_cmds", 64'(n_wr + n_rd), 64'd0);

        // start while busy is ignored
        run_test(2'd0, 22'h40, 22'h4F, 4, n);
        check("f_nwr", 64'(n_wr), 64'd16);
        check("f_nrd", 64'(n_rd), 64'd16);
        check("f_wrdata", 64'(wr_bad), 64'd0);
        check("f_pass", 64'(pass), 64'd1);
        check("f_cycles", 64'(n), 64'd35);

        // saturating error counter, 20 bad words
        corrupt_all = 1;
        run_test(2'd0, 22'h200, 22'h213, 0, n);
        check("g_err_sat", 64'(err_count), 64'd15);
        check("g_pass", 64'(pass), 64'd0);
        check("g_first_addr", 64'(first_err_addr), 64'h200);
        check("g_first_data", 64'(first_err_data), 64'h201);
        corrupt_all = 0;

        // reset during READ with 3 reads outstanding
        lat = 8;
        @(negedge clk);
        mode = 2'd0; base_addr = 22'h300; last_addr = 22'h30F; start = 1'b1; mode_exp = 2'd0;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (outst_tb != 3 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("h_reached_3", 64'(outst_tb), 64'd3);
        rst_n = 1'b0;
        #1;
        check("h_rst_read", 64'(avm_bus.avm_read), 64'd0);
        check("h_rst_busy", 64'(busy), 64'd0);
        check("h_rst_addr", 64'(avm_bus.avm_address), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (rq_due.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("h_drained", 64'(rq_due.size()), 64'd0);
        check("h_late_err", 64'(err_count), 64'd0);
        check("h_late_done", 64'(done), 64'd0);
        check("h_late_busy", 64'(busy), 64'd0);
        lat = 3;
        run_test(2'd1, 22'h300, 22'h30F, 0, n);
        check("h_clean_pass", 64'(pass), 64'd1);
        check("h_clean_err", 64'(err_count), 64'd0);
        check("h_clean_nrd", 64'(n_rd), 64'd16);
        check("h_clean_cycles", 64'(n), 64'd35);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
